ps2_event_sequencer: RTL and testbench
======================================

PS2_EVENT_SEQUENCER -- requirements
Module: ps2_event_sequencer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, event queue depth (power of two, 2..16).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 2_500_000, prefix timeout in Clock_50 cycles (50 ms).
REQ-003 SHALL have port Clock_50  input  1  single clock for all logic.
REQ-004 SHALL have port Resetn  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port PS2_code  input  8  received scan byte from the PS/2 receiver.
REQ-006 SHALL have port PS2_code_ready  input  1  level flag that rises once per received byte.
REQ-007 SHALL have port Event_ack  input  1  consumer pops the head event.
REQ-008 SHALL have port Clear_errors  input  1  synchronous clear of sticky flags.
REQ-009 SHALL have port Event_valid  output  1  FIFO non-empty.
REQ-010 SHALL have port Event_key  output  8  head event scan code.
REQ-011 SHALL have port Event_extended  output  1  head event carried the E0 prefix.
REQ-012 SHALL have port Event_make  output  1  head event is a make (1) or break (0).
REQ-013 SHALL have port Event_count  output  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
REQ-014 SHALL have port Overflow  output  1  sticky, event dropped while full.
REQ-015 SHALL have port Seq_error  output  1  sticky, malformed prefix sequence or timeout.
REQ-016 SHALL have port Key_state  output  4  held state {Down, Up, S, W}.

Function
REQ-017 SHALL register PS2_code_ready once; byte strobe = ready & ~ready_d, so one strobe per byte.
REQ-018 SHALL implement FSM S_IDLE, S_EXT, S_BREAK, S_EXT_BREAK, evaluated only on a byte strobe, except for the timeout in REQ-023.
REQ-019 In S_IDLE: byte E0 -> S_EXT; F0 -> S_BREAK; any other byte -> push {code, ext=0, make=1}, stay.
REQ-020 In S_EXT: F0 -> S_EXT_BREAK; E0 -> stay; other -> push {code, ext=1, make=1}, go to S_IDLE.
REQ-021 In S_BREAK: other -> push {code, 0, 0}; in S_EXT_BREAK: other -> push {code, 1, 0}; both then go to S_IDLE.
REQ-022 In S_BREAK or S_EXT_BREAK, an E0 or F0 byte SHALL set Seq_error, push nothing, and go to S_IDLE.
REQ-023 Timeout counter SHALL run while state != S_IDLE and restart on every strobe; on reaching TIMEOUT_CYCLES-1 it SHALL set Seq_error and force S_IDLE.
REQ-024 Push latency: strobe in cycle N -> entry written at end of N -> Event_valid=1 in cycle N+1 if FIFO was empty.
REQ-025 Pop occurs at end of any cycle with Event_valid & Event_ack; Event_ack while empty SHALL be ignored.
REQ-026 Push while full with no pop SHALL drop the event and set Overflow; push and pop in the same cycle while full SHALL both succeed, leaving count unchanged.
REQ-027 Push and pop in the same cycle while count=1 SHALL leave count=1, with the new entry at the head in cycle N+1.
REQ-028 When the FIFO is empty, Event_key, Event_extended and Event_make SHALL drive 0.
REQ-029 FIFO pointers SHALL wrap modulo FIFO_DEPTH; Event_count ranges 0..FIFO_DEPTH.
REQ-030 Clear_errors SHALL clear Overflow and Seq_error; a set event in the same cycle wins.

Reset
REQ-031 Resetn low SHALL immediately force: state S_IDLE, FIFO empty, Event_valid=0, Event_key=0, Event_extended=0, Event_make=0, Event_count=0, Overflow=0, Seq_error=0, Key_state=0, timeout counter=0, ready_d=0.
REQ-032 Reset asserted in the middle of a prefix sequence SHALL discard the partial sequence; the first byte after reset is decoded from S_IDLE.

Configuration
REQ-033 With PS2_KEY_STATE_EN defined, Key_state SHALL update one cycle after decode and regardless of FIFO fullness: W=1D, S=1B, Up=E0 75, Down=E0 72; a make sets the bit and a break clears it.
REQ-034 Without PS2_KEY_STATE_EN, Key_state SHALL be tied to 4'b0000 and no tracking logic SHALL be built.

Structure
REQ-035 Package ps2_seq_pkg SHALL hold the FSM state enum, the constants PS2_EXT=8'hE0 and PS2_BREAK=8'hF0, the four key codes, and the event struct {key[7:0], extended, make}.
REQ-036 FIFO storage and pointers SHALL be in sub-module ps2_event_fifo; decode, timeout and key state SHALL stay in the top module.

Verification
REQ-037 Strobe bytes 1D, then F0 1D -> events {1D,0,1} and {1D,0,0}; Key_state[0] is 1 after the first and 0 after the second.
REQ-038 Strobe E0 75, then E0 F0 75 -> events {75,1,1} and {75,1,0}; Key_state[2] toggles 1 then 0; Seq_error=0.
REQ-039 With Event_ack=0, push 5 make events (FIFO_DEPTH=4) -> Event_count=4, Overflow=1, fifth event lost; then pop 4 -> events 1..4 in order.
REQ-040 With FIFO full, assert Event_ack and a strobe in the same cycle -> count stays 4 and Overflow stays 0.
REQ-041 Strobe F0 then E0 -> Seq_error=1, no push; strobe E0 then idle for TIMEOUT_CYCLES -> Seq_error=1 and state S_IDLE.
REQ-042 Drop Resetn after E0 F0, then strobe 1B -> event {1B,0,1}.

Source files
------------

// File: rtl/ps2_seq_pkg.sv
// Shared types and constants for the PS/2 event sequencer.
// Holds the decoder state enum, the prefix bytes, the tracked key codes
// and the queued event record.
package ps2_seq_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXT,
        S_BREAK,
        S_EXT_BREAK
    } ps2_state_e;

    localparam logic [7:0] PS2_EXT   = 8'hE0;
    localparam logic [7:0] PS2_BREAK = 8'hF0;

    localparam logic [7:0] KEY_W    = 8'h1D;
    localparam logic [7:0] KEY_S    = 8'h1B;
    localparam logic [7:0] KEY_UP   = 8'h75;
    localparam logic [7:0] KEY_DOWN = 8'h72;

    typedef struct packed {
        logic [7:0] key;
        logic       extended;
        logic       make;
    } ps2_event_t;

endpackage

// File: rtl/ps2_event_fifo.sv
// Event queue for the PS/2 sequencer. Power-of-two depth, pointers wrap
// naturally. A push while full only lands if a pop happens in the same cycle.
// The head fields read as zero while the queue is empty.
module ps2_event_fifo
    import ps2_seq_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk_sys,
    input  logic                       rst_b,
    input  logic                       push,
    input  ps2_event_t                 push_data,
    input  logic                       pop,
    output ps2_event_t                 head,
    output logic                       valid,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    ps2_event_t          mem_q [DEPTH];
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]       count_q, count_d;
    logic                wr_en;
    logic                rd_en;

    // Pointer and occupancy update for the accepted push/pop pair
    always_comb begin
        valid    = (count_q != '0);
        full     = (count_q == CW'(DEPTH));
        rd_en    = pop & valid;
        wr_en    = push & (~full | rd_en);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
        if (rd_en) rd_ptr_d = rd_ptr_q + AW'(1);
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        head  = valid ? mem_q[rd_ptr_q] : '0;
        count = count_q;
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk_sys or negedge rst_b) begin
        if (!rst_b) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; empty entries are masked at the head
    always_ff @(posedge clk_sys) begin
        if (wr_en) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/ps2_event_sequencer.sv
// PS/2 scan-byte decoder: folds E0/F0 prefixes into make/break events,
// queues them, and flags overflow and malformed/stalled prefix sequences.
// Optional held-key tracking for W/S/Up/Down is built only when
// PS2_KEY_STATE_EN is defined; otherwise Key_state is tied low.
//
// state        | meaning
// S_IDLE       | no prefix pending
// S_EXT        | E0 seen, waiting for code or F0
// S_BREAK      | F0 seen, next code is a plain break
// S_EXT_BREAK  | E0 F0 seen, next code is an extended break
module ps2_event_sequencer
    import ps2_seq_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 2_500_000
) (
    input  logic                           Clock_50,
    input  logic                           Resetn,
    input  logic [7:0]                     PS2_code,
    input  logic                           PS2_code_ready,
    input  logic                           Event_ack,
    input  logic                           Clear_errors,
    output logic                           Event_valid,
    output logic [7:0]                     Event_key,
    output logic                           Event_extended,
    output logic                           Event_make,
    output logic [$clog2(FIFO_DEPTH):0]    Event_count,
    output logic                           Overflow,
    output logic                           Seq_error,
    output logic [3:0]                     Key_state
);

    localparam int              TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    ps2_state_e        state_q, state_d;
    logic              ready_q, ready_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic              overflow_q, overflow_d;
    logic              seq_err_q, seq_err_d;
    logic              strobe;
    logic              is_ext, is_brk;
    logic              push_valid;
    ps2_event_t        push_evt;
    logic              seq_err_set;
    logic              pop;
    logic              fifo_full;
    ps2_event_t        head;

    // Prefix decode, timeout and sticky-flag next state
    always_comb begin
        ready_d     = PS2_code_ready;
        strobe      = PS2_code_ready & ~ready_q;
        is_ext      = (PS2_code == PS2_EXT);
        is_brk      = (PS2_code == PS2_BREAK);
        state_d     = state_q;
        tmo_d       = tmo_q;
        push_valid  = 1'b0;
        push_evt    = '0;
        seq_err_set = 1'b0;
        if (strobe) begin
            tmo_d = '0;
            case (state_q)
                S_IDLE: begin
                    if (is_ext)      state_d = S_EXT;
                    else if (is_brk) state_d = S_BREAK;
                    else begin
                        push_valid = 1'b1;
                        push_evt   = '{key: PS2_code, extended: 1'b0, make: 1'b1};
                    end
                end
                S_EXT: begin
                    if (is_brk)      state_d = S_EXT_BREAK;
                    else if (!is_ext) begin
                        push_valid = 1'b1;
                        push_evt   = '{key: PS2_code, extended: 1'b1, make: 1'b1};
                        state_d    = S_IDLE;
                    end
                end
                S_BREAK, S_EXT_BREAK: begin
                    if (is_ext || is_brk) seq_err_set = 1'b1;
                    else begin
                        push_valid = 1'b1;
                        push_evt   = '{key: PS2_code,
                                       extended: (state_q == S_EXT_BREAK),
                                       make: 1'b0};
                    end
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end else if (state_q != S_IDLE) begin
            if (tmo_q == TMO_LAST) begin
                seq_err_set = 1'b1;
                state_d     = S_IDLE;
                tmo_d       = '0;
            end else begin
                tmo_d = tmo_q + TMO_W'(1);
            end
        end else begin
            tmo_d = '0;
        end

        pop        = Event_valid & Event_ack;
        overflow_d = (push_valid & fifo_full & ~pop) | (overflow_q & ~Clear_errors);
        seq_err_d  = seq_err_set | (seq_err_q & ~Clear_errors);
    end

    // Decoder state, byte-edge detector, timeout and sticky flags
    always_ff @(posedge Clock_50 or negedge Resetn) begin
        if (!Resetn) begin
            state_q    <= S_IDLE;
            ready_q    <= 1'b0;
            tmo_q      <= '0;
            overflow_q <= 1'b0;
            seq_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ready_q    <= ready_d;
            tmo_q      <= tmo_d;
            overflow_q <= overflow_d;
            seq_err_q  <= seq_err_d;
        end
    end

    ps2_event_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_sys   (Clock_50),
        .rst_b     (Resetn),
        .push      (push_valid),
        .push_data (push_evt),
        .pop       (pop),
        .head      (head),
        .valid     (Event_valid),
        .full      (fifo_full),
        .count     (Event_count)
    );

    // Head event fields and sticky flags out
    always_comb begin
        Event_key      = head.key;
        Event_extended = head.extended;
        Event_make     = head.make;
        Overflow       = overflow_q;
        Seq_error      = seq_err_q;
    end

`ifdef PS2_KEY_STATE_EN
    logic [3:0] key_q, key_d;

    // Held-key tracking follows every decoded event, even when it is dropped
    always_comb begin
        key_d = key_q;
        if (push_valid) begin
            if (!push_evt.extended && push_evt.key == KEY_W) key_d[0] = push_evt.make;
            if (!push_evt.extended && push_evt.key == KEY_S) key_d[1] = push_evt.make;
            if (push_evt.extended && push_evt.key == KEY_UP)   key_d[2] = push_evt.make;
            if (push_evt.extended && push_evt.key == KEY_DOWN) key_d[3] = push_evt.make;
        end
        Key_state = key_q;
    end

    // Held-key register
    always_ff @(posedge Clock_50 or negedge Resetn) begin
        if (!Resetn) key_q <= '0;
        else         key_q <= key_d;
    end
`else
    assign Key_state = 4'b0000;
`endif

endmodule

// File: tb/tb_ps2_event_sequencer.sv
// Directed bench for ps2_event_sequencer: a table of prefix sequences plus
// hand-written FIFO-full, simultaneous push/pop, timeout and reset cases.
module tb_ps2_event_sequencer;

    localparam int FIFO_DEPTH     = 4;
    localparam int TIMEOUT_CYCLES = 20;

`ifdef PS2_KEY_STATE_EN
    localparam logic [3:0] KS_MASK = 4'b1111;
`else
    localparam logic [3:0] KS_MASK = 4'b0000;
`endif

    logic        Clock_50 = 1'b0;
    logic        Resetn;
    logic [7:0]  PS2_code;
    logic        PS2_code_ready;
    logic        Event_ack;
    logic        Clear_errors;
    logic        Event_valid;
    logic [7:0]  Event_key;
    logic        Event_extended;
    logic        Event_make;
    logic [2:0]  Event_count;
    logic        Overflow;
    logic        Seq_error;
    logic [3:0]  Key_state;

    int checks   = 0;
    int failures = 0;

    ps2_event_sequencer #(
        .FIFO_DEPTH     (FIFO_DEPTH),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .Clock_50       (Clock_50),
        .Resetn         (Resetn),
        .PS2_code       (PS2_code),
        .PS2_code_ready (PS2_code_ready),
        .Event_ack      (Event_ack),
        .Clear_errors   (Clear_errors),
        .Event_valid    (Event_valid),
        .Event_key      (Event_key),
        .Event_extended (Event_extended),
        .Event_make     (Event_make),
        .Event_count    (Event_count),
        .Overflow       (Overflow),
        .Seq_error      (Seq_error),
        .Key_state      (Key_state)
    );

    always #5 Clock_50 = ~Clock_50;

    typedef struct {
        logic [7:0] b0;
        logic [7:0] b1;
        logic [7:0] b2;
        int         n;
        logic       ev;
        logic [7:0] key;
        logic       ext;
        logic       mk;
        logic       err;
        logic [3:0] ks;
    } vec_t;

    vec_t vecs [8];

    function automatic logic [3:0] kx(input logic [3:0] v);
        return v & KS_MASK;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge Clock_50);
        PS2_code       = b;
        PS2_code_ready = 1'b1;
        @(negedge Clock_50);
        PS2_code_ready = 1'b0;
    endtask

    task automatic pop_one();
        @(negedge Clock_50);
        Event_ack = 1'b1;
        @(negedge Clock_50);
        Event_ack = 1'b0;
    endtask

    task automatic clear_errs();
        @(negedge Clock_50);
        Clear_errors = 1'b1;
        @(negedge Clock_50);
        Clear_errors = 1'b0;
    endtask

    task automatic check_head(input string tag, input logic [7:0] key, input logic ext, input logic mk);
        check({tag, "_valid"}, Event_valid, 1'b1);
        check({tag, "_key"}, Event_key, key);
        check({tag, "_ext"}, Event_extended, ext);
        check({tag, "_make"}, Event_make, mk);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{8'h1D, 8'h00, 8'h00, 1, 1'b1, 8'h1D, 1'b0, 1'b1, 1'b0, 4'b0001};
        vecs[1] = '{8'hF0, 8'h1D, 8'h00, 2, 1'b1, 8'h1D, 1'b0, 1'b0, 1'b0, 4'b0000};
        vecs[2] = '{8'hE0, 8'h75, 8'h00, 2, 1'b1, 8'h75, 1'b1, 1'b1, 1'b0, 4'b0100};
        vecs[3] = '{8'hE0, 8'hF0, 8'h75, 3, 1'b1, 8'h75, 1'b1, 1'b0, 1'b0, 4'b0000};
        vecs[4] = '{8'hE0, 8'hE0, 8'h72, 3, 1'b1, 8'h72, 1'b1, 1'b1, 1'b0, 4'b1000};
        vecs[5] = '{8'h1B, 8'h00, 8'h00, 1, 1'b1, 8'h1B, 1'b0, 1'b1, 1'b0, 4'b1010};
        vecs[6] = '{8'hF0, 8'hE0, 8'h00, 2, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 4'b1010};
        vecs[7] = '{8'hE0, 8'hF0, 8'hF0, 3, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 4'b1010};

        Resetn         = 1'b0;
        PS2_code       = 8'h00;
        PS2_code_ready = 1'b0;
        Event_ack      = 1'b0;
        Clear_errors   = 1'b0;
        repeat (2) @(negedge Clock_50);
        check("rst_valid", Event_valid, 1'b0);
        check("rst_key", Event_key, 8'h00);
        check("rst_count", Event_count, 3'd0);
        check("rst_ovf", Overflow, 1'b0);
        check("rst_seqerr", Seq_error, 1'b0);
        check("rst_ks", Key_state, 4'b0000);
        Resetn = 1'b1;

        // Table of prefix sequences, each yielding at most one event
        for (int i = 0; i < 8; i++) begin
            clear_errs();
            for (int j = 0; j < vecs[i].n; j++)
                send_byte(j == 0 ? vecs[i].b0 : (j == 1 ? vecs[i].b1 : vecs[i].b2));
            check($sformatf("v%0d_valid", i), Event_valid, vecs[i].ev);
            check($sformatf("v%0d_key", i), Event_key, vecs[i].key);
            check($sformatf("v%0d_ext", i), Event_extended, vecs[i].ext);
            check($sformatf("v%0d_make", i), Event_make, vecs[i].mk);
            check($sformatf("v%0d_count", i), Event_count, vecs[i].ev ? 3'd1 : 3'd0);
            check($sformatf("v%0d_seqerr", i), Seq_error, vecs[i].err);
            check($sformatf("v%0d_ks", i), Key_state, kx(vecs[i].ks));
            if (vecs[i].ev) begin
                pop_one();
                check($sformatf("v%0d_empty_valid", i), Event_valid, 1'b0);
                check($sformatf("v%0d_empty_key", i), Event_key, 8'h00);
                check($sformatf("v%0d_empty_make", i), Event_make, 1'b0);
            end
        end

        // Overflow: five pushes into a depth-4 queue
        clear_errs();
        for (int k = 1; k <= 5; k++) send_byte(8'(k));
        check("ovf_count", Event_count, 3'd4);
        check("ovf_flag", Overflow, 1'b1);
        check("ovf_seqerr", Seq_error, 1'b0);
        clear_errs();
        check("ovf_cleared", Overflow, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            check_head($sformatf("ovf_pop%0d", k), 8'(k), 1'b0, 1'b1);
            pop_one();
        end
        check("ovf_drained_valid", Event_valid, 1'b0);
        check("ovf_drained_count", Event_count, 3'd0);

        // Push and pop in the same cycle while full
        for (int k = 1; k <= 4; k++) send_byte(8'h10 + 8'(k));
        check("full_count", Event_count, 3'd4);
        @(negedge Clock_50);
        PS2_code       = 8'h15;
        PS2_code_ready = 1'b1;
        Event_ack      = 1'b1;
        @(negedge Clock_50);
        PS2_code_ready = 1'b0;
        Event_ack      = 1'b0;
        check("fullpp_count", Event_count, 3'd4);
        check("fullpp_ovf", Overflow, 1'b0);
        for (int k = 2; k <= 5; k++) begin
            check_head($sformatf("fullpp_pop%0d", k), 8'h10 + 8'(k), 1'b0, 1'b1);
            pop_one();
        end
        check("fullpp_empty", Event_valid, 1'b0);

        // Push and pop in the same cycle at count one
        send_byte(8'h21);
        @(negedge Clock_50);
        PS2_code       = 8'h22;
        PS2_code_ready = 1'b1;
        Event_ack      = 1'b1;
        @(negedge Clock_50);
        PS2_code_ready = 1'b0;
        Event_ack      = 1'b0;
        check("one_count", Event_count, 3'd1);
        check_head("one_head", 8'h22, 1'b0, 1'b1);
        pop_one();
        check("one_empty", Event_count, 3'd0);

        // Prefix timeout
        clear_errs();
        send_byte(8'hE0);
        repeat (TIMEOUT_CYCLES - 1) @(negedge Clock_50);
        check("tmo_before", Seq_error, 1'b0);
        @(negedge Clock_50);
        check("tmo_fired", Seq_error, 1'b1);
        check("tmo_nopush", Event_valid, 1'b0);
        send_byte(8'h1D);
        check_head("tmo_idle", 8'h1D, 1'b0, 1'b1);
        check("tmo_ks", Key_state, kx(4'b1011));
        pop_one();

        // Reset in the middle of a prefix sequence
        clear_errs();
        send_byte(8'hE0);
        send_byte(8'hF0);
        @(negedge Clock_50);
        Resetn = 1'b0;
        #1;
        check("mid_rst_ks", Key_state, 4'b0000);
        check("mid_rst_count", Event_count, 3'd0);
        @(negedge Clock_50);
        Resetn = 1'b1;
        send_byte(8'h1B);
        check_head("mid_rst_ev", 8'h1B, 1'b0, 1'b1);
        check("mid_rst_seqerr", Seq_error, 1'b0);
        check("mid_rst_ks2", Key_state, kx(4'b0010));
        pop_one();
        check("mid_rst_empty", Event_valid, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
